// File: rtl/inst_encoder_if.sv
// Streaming handshake bundle for inst_encoder: decoded-field input stream,
// encoded-word output stream, synchronous clear and error reporting.
interface inst_encoder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              err_pulse;
    logic [7:0]        err_count;

    // Producer of fields and consumer of words.
    modport master (
        output clear, in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_inst, out_addr, err_pulse, err_count
    );

    // The encoder itself.
    modport slave (
        input  clear, in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_inst, out_addr, err_pulse, err_count
    );
endinterface

// File: rtl/inst_encoder.sv
// RISC-V I/S/SB instruction encoder with a single output register stage.
// Range-checks the signed immediate, packs the fields into a 32-bit word and
// tags it with a sequential byte address for instruction-memory loading.
module inst_encoder #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] ADDR_BASE = '0
) (
    input logic           clk,
    input logic           rst,
    inst_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        KindLoad   = 2'd0,
        KindOpImm  = 2'd1,
        KindStore  = 2'd2,
        KindBranch = 2'd3
    } kind_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_inst_q, out_inst_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              err_pulse_q, err_pulse_d;
    logic [7:0]        err_count_q, err_count_d;

    logic        in_ready;
    logic        accept;
    logic        xfer;
    logic        legal;
    logic [31:0] enc_inst;
    logic        is_shift;
    logic        imm12_ok;
    logic        imm13_ok;
    logic        shamt_ok;
    kind_e       kind;

    // Only combinational path through the block: out_ready -> in_ready.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready && !bus.clear;
    assign xfer     = out_valid_q && bus.out_ready;
    assign kind     = kind_e'(bus.in_kind);

    // Range checks: the immediate must sign-extend cleanly from the field width,
    // so every bit above the field's sign bit has to equal that sign bit.
    always_comb begin
        imm12_ok = (&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]);
        imm13_ok = (&bus.in_imm[31:12]) || !(|bus.in_imm[31:12]);
        shamt_ok = !(|bus.in_imm[31:5]);
        is_shift = (kind == KindOpImm) &&
                   ((bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101));
    end

    // Field packing and legality per instruction format.
    always_comb begin
        legal    = 1'b0;
        enc_inst = '0;
        unique case (kind)
            KindLoad: begin
                legal    = imm12_ok;
                enc_inst = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OpLoad};
            end
            KindOpImm: begin
                if (is_shift) begin
                    legal    = shamt_ok;
                    enc_inst = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1, bus.in_funct3,
                                bus.in_rd, OpOpImm};
                end else begin
                    legal    = imm12_ok;
                    enc_inst = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OpOpImm};
                end
            end
            KindStore: begin
                legal    = imm12_ok;
                enc_inst = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            bus.in_imm[4:0], OpStore};
            end
            KindBranch: begin
                // Branch offsets are halfword aligned; bit 0 is not encoded.
                legal    = imm13_ok && !bus.in_imm[0];
                enc_inst = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                            bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], OpBranch};
            end
            default: begin
                legal    = 1'b0;
                enc_inst = '0;
            end
        endcase
    end

    // Next-state: clear outranks everything; otherwise a transfer and an accept
    // may happen in the same cycle, giving back-to-back throughput.
    always_comb begin
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_addr_d  = out_addr_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        if (bus.clear) begin
            out_valid_d = 1'b0;
            out_addr_d  = ADDR_BASE;
        end else begin
            if (xfer) begin
                out_valid_d = 1'b0;
                out_addr_d  = out_addr_q + ADDR_W'(4);
            end
            if (accept) begin
                if (legal) begin
                    out_inst_d  = enc_inst;
                    out_valid_d = 1'b1;
                end else begin
                    err_pulse_d = 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
            end
        end
    end

    // State registers with asynchronous reset; reset drops any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_addr_q  <= ADDR_BASE;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_addr_q  <= out_addr_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: stimulus pushes expected words and error
// counts into queues, a negedge monitor pops and compares on each DUT output.
module tb_inst_encoder;

    localparam int unsigned ADDR_W = 4;
    localparam logic [3:0]  BASE   = 4'd12;

    localparam logic [1:0] KindLoad   = 2'd0;
    localparam logic [1:0] KindOpImm  = 2'd1;
    localparam logic [1:0] KindStore  = 2'd2;
    localparam logic [1:0] KindBranch = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        legal;
        logic [31:0] inst;
    } vec_t;

    logic clk;
    logic rst;

    inst_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder #(
        .ADDR_W    (ADDR_W),
        .ADDR_BASE (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks;
    int          failures;
    logic [31:0] exp_q[$];
    logic [7:0]  err_q[$];
    logic [3:0]  exp_addr;
    logic [7:0]  exp_errs;
    vec_t        tbl[14];
    vec_t        va;
    vec_t        vb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic flush_model();
        exp_q.delete();
        err_q.delete();
        exp_addr = BASE;
        exp_errs = 8'd0;
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid  = 1'b1;
        bus.in_kind   = v.kind;
        bus.in_rd     = v.rd;
        bus.in_rs1    = v.rs1;
        bus.in_rs2    = v.rs2;
        bus.in_funct3 = v.f3;
        bus.in_funct7 = v.f7;
        bus.in_imm    = v.imm;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic wait_accept(input vec_t v, input string name);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready && !bus.clear;
            if (acc) begin
                if (v.legal) begin
                    exp_q.push_back(v.inst);
                end else begin
                    if (exp_errs != 8'hFF) exp_errs = exp_errs + 8'd1;
                    err_q.push_back(exp_errs);
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL %s: accept timeout got in_ready=%b want 1", name, bus.in_ready);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every output transfer and every error pulse.
    initial begin
        logic [31:0] w;
        logic [7:0]  e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready && !bus.clear) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_word: got %h@%h want none", bus.out_inst, bus.out_addr);
                end else begin
                    w = exp_q.pop_front();
                    if (bus.out_inst !== w || bus.out_addr !== exp_addr) begin
                        failures++;
                        $display("FAIL out_word: got %h@%h want %h@%h",
                                 bus.out_inst, bus.out_addr, w, exp_addr);
                    end
                end
                exp_addr = exp_addr + 4'd4;
            end
            if (!rst && bus.err_pulse) begin
                checks++;
                if (err_q.size() == 0) begin
                    failures++;
                    $display("FAIL err_pulse: got pulse count=%0d want none", bus.err_count);
                end else begin
                    e = err_q.pop_front();
                    if (bus.err_count !== e) begin
                        failures++;
                        $display("FAIL err_count: got %0d want %0d", bus.err_count, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        flush_model();
        // kind rd rs1 rs2 f3 f7 imm legal inst
        tbl[0]  = '{KindOpImm,  5'd1,  5'd1,  5'd0,  3'd1, 7'h00, 32'd3,        1'b1, 32'h00309093};
        tbl[1]  = '{KindOpImm,  5'd2,  5'd3,  5'd0,  3'd5, 7'h20, 32'd31,       1'b1, 32'h41F1D113};
        tbl[2]  = '{KindOpImm,  5'd1,  5'd1,  5'd0,  3'd1, 7'h00, 32'd32,       1'b0, 32'h0};
        tbl[3]  = '{KindOpImm,  5'd1,  5'd1,  5'd0,  3'd5, 7'h00, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[4]  = '{KindOpImm,  5'd1,  5'd0,  5'd0,  3'd0, 7'h7F, 32'hFFFFF800, 1'b1, 32'h80000093};
        tbl[5]  = '{KindOpImm,  5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h000007FF, 1'b1, 32'h7FF00093};
        tbl[6]  = '{KindBranch, 5'd31, 5'd0,  5'd0,  3'd1, 7'h00, 32'h00000FFE, 1'b1, 32'h7E001FE3};
        tbl[7]  = '{KindBranch, 5'd31, 5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFF000, 1'b1, 32'h80000063};
        tbl[8]  = '{KindBranch, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00001000, 1'b0, 32'h0};
        tbl[9]  = '{KindStore,  5'd0,  5'd0,  5'd0,  3'd2, 7'h00, 32'hFFFFF7FF, 1'b0, 32'h0};
        tbl[10] = '{KindLoad,   5'd1,  5'd1,  5'd0,  3'd2, 7'h00, 32'h00010000, 1'b0, 32'h0};
        tbl[11] = '{KindLoad,   5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h80000000, 1'b0, 32'h0};
        tbl[12] = '{KindStore,  5'd31, 5'd0,  5'd31, 3'd0, 7'h00, 32'h000007FF, 1'b1, 32'h7FF00FA3};
        tbl[13] = '{KindLoad,   5'd10, 5'd11, 5'd31, 3'd4, 7'h00, 32'hFFFFFFFF, 1'b1, 32'hFFF5C503};

        rst           = 1'b1;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_kind   = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_funct3 = '0;
        bus.in_funct7 = '0;
        bus.in_imm    = '0;
        cycles(2);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_inst", bus.out_inst, 32'h0);
        check("rst_out_addr", 32'(bus.out_addr), 32'(BASE));
        check("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        cycles(1);

        // Single load, held then transferred.
        va = '{KindLoad, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 32'd8, 1'b1, 32'h00812283};
        drive(va);
        wait_accept(va, "load");
        idle();
        check("load_valid", 32'(bus.out_valid), 32'd1);
        check("load_inst", bus.out_inst, 32'h00812283);
        check("load_addr", 32'(bus.out_addr), 32'(BASE));
        bus.out_ready = 1'b1;
        cycles(1);
        check("load_addr_next", 32'(bus.out_addr), 32'd0);
        check("load_valid_after", 32'(bus.out_valid), 32'd0);

        // Store then branch, streamed.
        va = '{KindStore,  5'd0, 5'd2, 5'd6, 3'd2, 7'h00, 32'hFFFFFFFC, 1'b1, 32'hFE612E23};
        vb = '{KindBranch, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFF8, 1'b1, 32'hFE208CE3};
        drive(va);
        wait_accept(va, "store");
        drive(vb);
        wait_accept(vb, "branch");
        check("stream_second_inst", bus.out_inst, 32'hFE208CE3);
        check("stream_second_addr", 32'(bus.out_addr), 32'd4);
        idle();
        cycles(3);

        // Rejections.
        va = '{KindBranch, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd5, 1'b0, 32'h0};
        drive(va);
        wait_accept(va, "rej_branch");
        idle();
        check("rej_pulse", 32'(bus.err_pulse), 32'd1);
        check("rej_count1", 32'(bus.err_count), 32'd1);
        check("rej_no_valid", 32'(bus.out_valid), 32'd0);
        cycles(1);
        check("rej_pulse_gone", 32'(bus.err_pulse), 32'd0);
        va = '{KindOpImm, 5'd1, 5'd1, 5'd0, 3'd0, 7'h00, 32'd2048, 1'b0, 32'h0};
        drive(va);
        wait_accept(va, "rej_opimm");
        idle();
        cycles(1);
        check("rej_count2", 32'(bus.err_count), 32'd2);
        check("rej_addr_same", 32'(bus.out_addr), 32'(exp_addr));

        // Directed table, streamed at full rate.
        foreach (tbl[i]) begin
            drive(tbl[i]);
            wait_accept(tbl[i], "table");
        end
        idle();
        cycles(3);

        // Backpressure: word held, next input stalled.
        bus.out_ready = 1'b0;
        drive(tbl[0]);
        wait_accept(tbl[0], "bp_first");
        drive(tbl[1]);
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_inst_stable", bus.out_inst, tbl[0].inst);
            check("bp_addr_stable", 32'(bus.out_addr), 32'(exp_addr));
            @(posedge clk);
        end
        #1;
        bus.out_ready = 1'b1;
        wait_accept(tbl[1], "bp_second");
        idle();
        cycles(3);

        // Clear with a held word and a pending input.
        bus.out_ready = 1'b0;
        drive(tbl[13]);
        wait_accept(tbl[13], "clr_word");
        drive(tbl[12]);
        bus.clear     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("clr_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        idle();
        exp_q.delete();
        exp_addr = BASE;
        check("clr_valid", 32'(bus.out_valid), 32'd0);
        check("clr_addr", 32'(bus.out_addr), 32'(BASE));
        cycles(1);
        check("clr_not_taken", 32'(bus.out_valid), 32'd0);
        check("clr_err_kept", 32'(bus.err_count), 32'(exp_errs));

        // Error counter saturation.
        va = '{KindBranch, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 1'b0, 32'h0};
        for (int k = 0; k < 260; k++) begin
            drive(va);
            wait_accept(va, "sat");
        end
        idle();
        cycles(2);
        check("sat_count", 32'(bus.err_count), 32'd255);

        // Async reset mid-cycle while err_pulse and a stale word are present.
        drive(tbl[5]);
        wait_accept(tbl[5], "ar_word");
        drive(va);
        wait_accept(va, "ar_rej");
        idle();
        bus.out_ready = 1'b0;
        check("ar_pulse_pre", 32'(bus.err_pulse), 32'd1);
        #2;
        rst = 1'b1;
        flush_model();
        #1;
        check("ar_valid", 32'(bus.out_valid), 32'd0);
        check("ar_inst", bus.out_inst, 32'h0);
        check("ar_addr", 32'(bus.out_addr), 32'(BASE));
        check("ar_pulse", 32'(bus.err_pulse), 32'd0);
        check("ar_count", 32'(bus.err_count), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cycles(1);

        // Async reset drops a held word; next word lands at the base address.
        drive(tbl[6]);
        wait_accept(tbl[6], "ar2_word");
        idle();
        check("ar2_held", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        flush_model();
        #1;
        check("ar2_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cycles(1);
        check("ar2_dropped", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        drive(tbl[7]);
        wait_accept(tbl[7], "ar2_after");
        idle();
        check("ar2_first_addr", 32'(bus.out_addr), 32'(BASE));
        cycles(3);

        check("words_pending", 32'(exp_q.size()), 32'd0);
        check("errs_pending", 32'(err_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RISC-V instruction encoder for the single-cycle core's instruction-memory load path. It accepts decoded fields (format kind, registers, funct3, signed immediate) over a valid/ready handshake. It range-checks the immediate, packs the fields into a 32-bit I/S/SB word, and presents the word with a sequential byte address for writing into instruction memory. It is the inverse of immediate generation: every word it emits must decode back to the same immediate.

## Interface
- `ADDR_W`, 32: width of `out_addr`.
- `ADDR_BASE`, 0: address of the first emitted word, and the value restored by reset and `clear`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous. Drops any held output word and reloads the address to `ADDR_BASE`. Error count is unaffected.
- `in_valid`  in  1  the input fields are valid.
- `in_ready`  out  1  the encoder accepts the input this cycle.
- `in_kind`  in  2  0 = LOAD (opcode 0000011), 1 = OPIMM (0010011), 2 = STORE (0100011), 3 = BRANCH (1100011).
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices. `in_rd` is ignored for STORE and BRANCH; `in_rs2` is ignored for LOAD and OPIMM.
- `in_funct3`  in  3  funct3 field.
- `in_funct7`  in  7  used only for OPIMM shifts (funct3 001/101).
- `in_imm`  in  32  signed byte-offset or immediate.
- `out_valid`  out  1  the encoded word is held.
- `out_ready`  in  1  the consumer takes the word.
- `out_inst`  out  32  encoded instruction.
- `out_addr`  out  ADDR_W  byte address of `out_inst`.
- `err_pulse`  out  1  one-cycle flag: the accepted input was rejected.
- `err_count`  out  8  saturating count of rejected inputs.

## Operation
- Single output register stage. `in_ready = !out_valid || out_ready`, combinational.
- **Accept** means `in_valid && in_ready && !clear`. On accept the encoder range-checks the input and then encodes it:
  - **I (LOAD, OPIMM non-shift):** imm must be in -2048..2047. The word is {imm[11:0], rs1, funct3, rd, opcode}.
  - **OPIMM shift (funct3 001 or 101):** imm must be in 0..31. The word is {funct7, imm[4:0], rs1, funct3, rd, opcode}.
  - **S (STORE):** imm must be in -2048..2047. The word is {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - **SB (BRANCH):** imm must be in -4096..4094 and imm[0] must be 0. The word is {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - The range check examines all 32 bits of `in_imm`. A value is legal only if it sign-extends cleanly from the field width.
- **Legal accept:** load `out_inst`, set `out_valid`.
- **Illegal accept:** the word is discarded. `out_valid` is unchanged by this input. `err_pulse` is high the following cycle, and `err_count` increments, saturating at 255.
- **Address:** `out_addr` advances by 4 on each output transfer (`out_valid && out_ready`). It wraps modulo 2^ADDR_W with no flag. Rejected inputs do not advance the address.
- **Simultaneous transfer and accept:** the old word leaves and the new word loads in the same cycle, with no bubble. Sustained throughput is 1 word per cycle.
- **`clear` priority:** `clear` outranks accept and transfer. In a `clear` cycle:
  - `out_valid` goes to 0 and `out_addr` goes to `ADDR_BASE`.
  - The input is not accepted, even if `in_ready` is high.
- **Reset values:**
  - `out_valid`, `err_pulse` = 0
  - `out_inst` = 0x00000000
  - `out_addr` = `ADDR_BASE`
  - `err_count` = 0
  - Reset asserted mid-transfer drops the held word.

## Timing
- Latency: an input accepted at edge N is visible on `out_inst`/`out_valid` after edge N; the consumer can take it at edge N+1.
- `out_inst` and `out_addr` stay stable while `out_valid && !out_ready`. `in_ready` is low in that state.
- `err_pulse` is registered: high for exactly the one cycle after the rejecting edge.
- No combinational path from `in_*` to `out_*`. The only combinational path is `out_ready` to `in_ready`.

## Test plan
- **Load:** LOAD rd=5, rs1=2, f3=010, imm=8 -> `out_inst`=0x00812283 at `out_addr`=`ADDR_BASE`. After transfer, `out_addr`=`ADDR_BASE`+4.
- **Store/branch stream:** STORE rs2=6, rs1=2, f3=010, imm=-4, then BRANCH rs1=1, rs2=2, f3=000, imm=-8, streamed with `out_ready`=1 -> 0xFE612E23 then 0xFE208CE3 on consecutive cycles, at consecutive addresses.
- **Rejections:** BRANCH imm=5 -> rejected, `err_pulse` for 1 cycle, `err_count`=1, no `out_valid`. Then OPIMM f3=000 imm=2048 -> rejected, `err_count`=2, address unchanged.
- **Backpressure:** `out_ready`=0 for 5 cycles with `in_valid` held -> `in_ready`=0, `out_inst` and `out_addr` stable. On release, both words transfer in order with no loss or duplication.
- **Wrap and clear:** `ADDR_W`=4, `ADDR_BASE`=12, two transfers -> addresses 12 then 0 (wrap). Then `clear` with `in_valid`=1 -> input not taken, `out_valid`=0, `out_addr`=12.
- **Async reset:** assert `rst` mid-stream between clock edges -> all outputs take their reset values immediately. The first word after release lands at `ADDR_BASE`.
